// File: rtl/klingon_rx.sv
// klingon_rx: debounced 7-segment pattern receiver.
// Qualified samples of seg_in must repeat STABLE_CYCLES times before a pattern is
// accepted. An accepted pattern is matched against the 16-entry klingon code table.
// A hit is presented as a digit on a valid/ready output. A miss pulses err.
// STABLE_CYCLES legal range is 1..15.
module klingon_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       seg_en,
  input  logic [6:0] seg_in,
  output logic [3:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       err,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StHold} state_e;

  state_e     state_q, state_d;
  logic [6:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       err_q, err_d;
  logic       ovf_q, ovf_d;

  logic       load;
  logic       accept;
  logic       hit;
  logic [3:0] idx;
  logic       transfer;

  // Klingon encoder output O for input I = n; the decoder inverts this table.
  function automatic logic [6:0] seg_code(input logic [3:0] n);
    unique case (n)
      4'h0:    seg_code = 7'h3F;
      4'h1:    seg_code = 7'h06;
      4'h2:    seg_code = 7'h5B;
      4'h3:    seg_code = 7'h4F;
      4'h4:    seg_code = 7'h66;
      4'h5:    seg_code = 7'h6D;
      4'h6:    seg_code = 7'h7D;
      4'h7:    seg_code = 7'h07;
      4'h8:    seg_code = 7'h7F;
      4'h9:    seg_code = 7'h6F;
      4'hA:    seg_code = 7'h77;
      4'hB:    seg_code = 7'h7C;
      4'hC:    seg_code = 7'h39;
      4'hD:    seg_code = 7'h5E;
      4'hE:    seg_code = 7'h79;
      default: seg_code = 7'h71;
    endcase
  endfunction

  // Debounce FSM next state: track candidate pattern and its repeat count.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (seg_en) load = 1'b1;
      end
      StSettle: begin
        if (!seg_en) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (seg_in == cand_q) begin
          cnt_d = cnt_q + 4'd1;
          if ((cnt_q + 4'd1) == StableCnt) begin
            accept  = 1'b1;
            state_d = StHold;
          end
        end else begin
          load = 1'b1;
        end
      end
      StHold: begin
        if (!seg_en) state_d = StIdle;
        else if (seg_in != cand_q) load = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    // A fresh sample always counts as the first match; with a count of one it accepts at once.
    if (load) begin
      cand_d = seg_in;
      cnt_d  = 4'd1;
      if (StableCnt == 4'd1) begin
        accept  = 1'b1;
        state_d = StHold;
      end else begin
        state_d = StSettle;
      end
    end
  end

  // Exact-match lookup of the accepted pattern (seg_in equals cand on every accept).
  always_comb begin
    hit = 1'b0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg_code(4'(i)) == seg_in) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  end

  // Output stage: one-entry holding register with overflow and error reporting.
  always_comb begin
    transfer     = dout_valid_q & dout_ready;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ovf_d        = ovf_q;
    err_d        = accept & ~hit;
    if (transfer) dout_valid_d = 1'b0;
    if (ovf_clr) ovf_d = 1'b0;
    if (accept && hit) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = idx;
        dout_valid_d = 1'b1;
      end else begin
        // Holding register still owned by the consumer: drop the new digit.
        ovf_d = 1'b1;
      end
    end
  end

  // All state registers; reset aborts any settle and discards a pending digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cand_q       <= 7'd0;
      cnt_q        <= 4'd0;
      dout_q       <= 4'd0;
      dout_valid_q <= 1'b0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign err        = err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_klingon_rx.sv
// Self-checking bench for klingon_rx: scenario tasks plus a transfer scoreboard.
module tb_klingon_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       seg_en;
  logic [6:0] seg_in;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       err;
  logic       ovf;
  logic       ovf_clr;

  logic [3:0] enc_i;
  logic       use_raw;
  logic [6:0] raw_seg;

  int checks = 0;
  int errors = 0;
  int transfers = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  // Reference klingon encoder: O for input I.
  function automatic logic [6:0] klingon(input logic [3:0] i);
    case (i)
      4'h0: klingon = 7'h3F; 4'h1: klingon = 7'h06; 4'h2: klingon = 7'h5B;
      4'h3: klingon = 7'h4F; 4'h4: klingon = 7'h66; 4'h5: klingon = 7'h6D;
      4'h6: klingon = 7'h7D; 4'h7: klingon = 7'h07; 4'h8: klingon = 7'h7F;
      4'h9: klingon = 7'h6F; 4'hA: klingon = 7'h77; 4'hB: klingon = 7'h7C;
      4'hC: klingon = 7'h39; 4'hD: klingon = 7'h5E; 4'hE: klingon = 7'h79;
      default: klingon = 7'h71;
    endcase
  endfunction

  assign seg_in = use_raw ? raw_seg : klingon(enc_i);

  klingon_rx #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_en    (seg_en),
    .seg_in    (seg_in),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .err       (err),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // Scoreboard: every transfer pops the oldest expected digit.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      transfers++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got digit %0d, expected none", dout);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL scoreboard_value: got %0d, expected %0d", dout, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input int n);
    seg_en = 1'b0;
    use_raw = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; seg_en = 1'b0; enc_i = 4'd0; use_raw = 1'b0; raw_seg = 7'd0;
    dout_ready = 1'b1; ovf_clr = 1'b0;
    #12;
    checks++;
    if ({dout, dout_valid, err, ovf} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got %b, expected 0000000", {dout, dout_valid, err, ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_digit();
    int t0;
    t0 = transfers;
    exp_q.push_back(4'd5);
    seg_en = 1'b1; enc_i = 4'd5;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e <= 4) begin
        checks++;
        if (dout_valid !== (e == 4)) begin
          errors++;
          $display("FAIL single_latency edge %0d: valid %b, expected %b", e, dout_valid, e == 4);
        end
      end
      if (e == 4) begin
        checks++;
        if (dout !== 4'd5) begin
          errors++;
          $display("FAIL single_value: got %0d, expected 5", dout);
        end
      end
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL single_err edge %0d: got %b, expected 0", e, err);
      end
    end
    checks++;
    if (transfers - t0 != 1) begin
      errors++;
      $display("FAIL single_count: got %0d digits, expected 1", transfers - t0);
    end
    go_idle(2);
  endtask

  task automatic test_sweep();
    int t0;
    int errs;
    t0 = transfers;
    errs = 0;
    seg_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      enc_i = 4'(i);
      exp_q.push_back(4'(i));
      for (int c = 0; c < 6; c++) begin
        tick();
        if (err !== 1'b0 || ovf !== 1'b0) errs++;
      end
    end
    go_idle(2);
    checks++;
    if (transfers - t0 != 16) begin
      errors++;
      $display("FAIL sweep_count: got %0d digits, expected 16", transfers - t0);
    end
    checks++;
    if (errs != 0) begin
      errors++;
      $display("FAIL sweep_flags: err/ovf high in %0d cycles, expected 0", errs);
    end
  endtask

  task automatic test_glitch();
    int t0;
    t0 = transfers;
    seg_en = 1'b1; enc_i = 4'd3;
    for (int c = 0; c < 3; c++) tick();
    enc_i = 4'd9;
    exp_q.push_back(4'd9);
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (dout_valid !== (e == 4)) begin
        errors++;
        $display("FAIL glitch_latency edge %0d: valid %b, expected %b", e, dout_valid, e == 4);
      end
    end
    checks++;
    if (dout !== 4'd9) begin
      errors++;
      $display("FAIL glitch_value: got %0d, expected 9", dout);
    end
    go_idle(3);
    checks++;
    if (transfers - t0 != 1) begin
      errors++;
      $display("FAIL glitch_count: got %0d digits, expected 1", transfers - t0);
    end
  endtask

  task automatic test_invalid();
    logic [6:0] bad;
    logic       found;
    bad = 7'd0;
    found = 1'b0;
    for (int v = 0; v < 128 && !found; v++) begin
      logic in_tbl;
      in_tbl = 1'b0;
      for (int i = 0; i < 16; i++) if (klingon(4'(i)) == 7'(v)) in_tbl = 1'b1;
      if (!in_tbl) begin
        bad = 7'(v);
        found = 1'b1;
      end
    end
    raw_seg = bad; use_raw = 1'b1; seg_en = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (err !== (e == 4)) begin
        errors++;
        $display("FAIL invalid_err edge %0d: got %b, expected %b", e, err, e == 4);
      end
      checks++;
      if (dout_valid !== 1'b0) begin
        errors++;
        $display("FAIL invalid_valid edge %0d: got %b, expected 0", e, dout_valid);
      end
    end
    go_idle(2);
  endtask

  task automatic test_overflow();
    int unstable;
    unstable = 0;
    dout_ready = 1'b0;
    seg_en = 1'b1; enc_i = 4'd2;
    exp_q.push_back(4'd2);
    for (int c = 0; c < 4; c++) tick();
    enc_i = 4'd7;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dout !== 4'd2 || dout_valid !== 1'b1) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL ovf_hold: dout changed in %0d cycles, expected stable 2", unstable);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: got %b, expected 1", ovf);
    end
    seg_en = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr: got %b, expected 0", ovf);
    end
    checks++;
    if (dout !== 4'd2 || dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pending: got %0d/%b, expected 2/1", dout, dout_valid);
    end
    dout_ready = 1'b1;
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain: valid %b, expected 0", dout_valid);
    end
    go_idle(2);
  endtask

  task automatic test_mid_reset();
    seg_en = 1'b1; enc_i = 4'd6;
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, err, ovf} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset: got %b, expected 0000000", {dout, dout_valid, err, ovf});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(4'd6);
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++;
      if (dout_valid !== (e == 4)) begin
        errors++;
        $display("FAIL reset_resettle edge %0d: valid %b, expected %b", e, dout_valid, e == 4);
      end
    end
    checks++;
    if (dout !== 4'd6) begin
      errors++;
      $display("FAIL reset_value: got %0d, expected 6", dout);
    end
    go_idle(2);
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_sweep();
    test_glitch();
    test_invalid();
    test_overflow();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/klingon_rx.md
KLINGON_RX -- requirements
Module: klingon_rx

Interface
REQ-001 STABLE_CYCLES, default 4: consecutive identical qualified samples required before a pattern is accepted; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 seg_en  input  1  sample qualifier; seg_in is ignored while 0.
REQ-005 seg_in  input  7  segment pattern, bit order identical to klingon output O[6:0].
REQ-006 dout  output  4  decoded digit.
REQ-007 dout_valid  output  1  dout holds an untransferred digit.
REQ-008 dout_ready  input  1  consumer accepts dout this cycle.
REQ-009 err  output  1  one-cycle pulse when an accepted pattern is not in the decode table.
REQ-010 ovf  output  1  sticky flag: a valid digit was dropped.
REQ-011 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-012 The decode table SHALL hold 16 entries; entry n SHALL equal the klingon output O for I=n; decode is an exact 7-bit match.
REQ-013 Internal state SHALL be a candidate register cand[6:0], a match counter cnt[3:0], and an FSM with states IDLE, SETTLE and HOLD.
REQ-014 In IDLE, seg_en=1 SHALL load cand=seg_in and cnt=1, then move to SETTLE; with STABLE_CYCLES=1 it SHALL accept immediately and move to HOLD.
REQ-015 In SETTLE, seg_en=1 with seg_in==cand SHALL increment cnt; the sample that makes cnt equal STABLE_CYCLES SHALL accept cand and move to HOLD.
REQ-016 In SETTLE, seg_en=1 with seg_in!=cand SHALL reload cand=seg_in and cnt=1 and stay in SETTLE; seg_en=0 SHALL return to IDLE with no accept.
REQ-017 In HOLD, an unchanged qualified pattern SHALL produce no further accepts.
REQ-018 In HOLD, seg_en=0 SHALL move to IDLE; a changed qualified pattern SHALL reload cand, set cnt=1 and move to SETTLE.
REQ-019 Latency: a pattern first sampled at edge k SHALL produce dout_valid=1 (or err=1) visible after edge k+STABLE_CYCLES-1.
REQ-020 A valid accept SHALL load dout with the table index and set dout_valid.
REQ-021 An invalid accept SHALL pulse err for exactly one cycle and leave dout and dout_valid unchanged.
REQ-022 A transfer SHALL occur when dout_valid & dout_ready; dout_valid SHALL fall on the next edge unless a valid accept occurs on that same edge, in which case dout SHALL load the new digit and dout_valid SHALL stay 1.
REQ-023 A valid accept while dout_valid=1 & dout_ready=0 SHALL drop the new digit, keep dout unchanged and set ovf.
REQ-024 dout SHALL remain stable while dout_valid=1 and dout_ready=0.
REQ-025 ovf_clr SHALL clear ovf; on the same edge as a new overflow, set SHALL win.

Reset
REQ-026 rst=1 SHALL immediately force dout=0, dout_valid=0, err=0, ovf=0, cand=0, cnt=0 and state IDLE.
REQ-027 Reset mid-operation SHALL abort any partial settle and discard any pending dout; after release a full STABLE_CYCLES of new samples is required before any accept.

Verification
The bench drives seg_in from an instantiated klingon encoder (input I). STABLE_CYCLES=4 and dout_ready=1 unless stated.
REQ-028 Reset, seg_en=1, I=5 held 20 cycles -> exactly one digit, dout=5, dout_valid high after the 4th sampling edge, err=0 throughout.
REQ-029 Sweep I=0..15, each held 6 cycles -> exactly 16 transfers with values 0..15 in order; err and ovf stay 0.
REQ-030 I=3 held 3 cycles, then I=9 held 4 cycles -> no digit 3; one digit 9 appears after the 4th I=9 sample.
REQ-031 seg_in forced to a bench-computed 7-bit value absent from all 16 klingon outputs, held 4 cycles -> err high for exactly one cycle, dout_valid=0.
REQ-032 dout_ready=0, digits 2 then 7 accepted -> dout stays 2, ovf=1; pulse ovf_clr -> ovf=0; set dout_ready=1 -> digit 2 transfers, dout_valid=0 on the next cycle.
REQ-033 rst asserted after 2 of 4 samples of I=6 -> outputs go to 0 without waiting for a clock edge; after release, the digit 6 appears only after 4 further samples.
